// File: rtl/gelato_fetch_scheduler_pkg.sv
// Shared fetch-scheduler types: addresses, warp ids, split-table ids
// and the per-warp fetch state.
package gelato_types;

    typedef logic [31:0] addr_t;
    typedef logic [4:0]  warp_num_t;
    typedef logic [3:0]  split_table_num_t;

    typedef enum logic [1:0] {
        IDLE,
        READY,
        WAIT
    } fetch_state_e;

    typedef struct packed {
        addr_t            pc;
        split_table_num_t split_table_num;
    } fetch_ctx_t;

endpackage

// File: rtl/gelato_fetchskd_ifetch_if.sv
// Issue channel from the fetch scheduler to I-Fetch.
interface gelato_fetchskd_ifetch_if;
    import gelato_types::*;

    logic             valid;
    addr_t            pc;
    warp_num_t        warp_num;
    split_table_num_t split_table_num;

    modport master (
        output valid,
        output pc,
        output warp_num,
        output split_table_num
    );

    modport slave (
        input valid,
        input pc,
        input warp_num,
        input split_table_num
    );

endinterface

// File: rtl/gelato_fetch_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first request at or after ptr,
// wrapping, found by scanning a doubled request vector.
module gelato_rr_arbiter #(
    parameter int N  = 32,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          gnt_valid,
    output logic [IW-1:0] gnt_idx
);

    logic [2*N-2:0] dbl;
    logic [IW:0]    pos;

    assign dbl = {req[N-2:0], req};

    // Scan downward so the lowest offset from ptr wins.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        pos       = '0;
        for (int i = N - 1; i >= 0; i--) begin
            pos = {1'b0, ptr} + (IW + 1)'(i);
            if (dbl[pos]) begin
                gnt_valid = 1'b1;
                gnt_idx   = pos[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/gelato_fetch_scheduler.sv
// Per-SM fetch scheduler: tracks every warp's fetch state and issues
// one READY warp per cycle to I-Fetch in round-robin order.
module gelato_fetch_scheduler
    import gelato_types::*;
#(
    parameter int NUM_WARPS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              launch_valid,
    input  warp_num_t         launch_warp_num,
    input  addr_t             launch_pc,
    input  split_table_num_t  launch_split_table_num,
    input  logic              update_valid,
    input  warp_num_t         update_warp_num,
    input  addr_t             update_pc,
    input  split_table_num_t  update_split_table_num,
    input  logic              finish_valid,
    input  warp_num_t         finish_warp_num,
    input  logic              ifetch_ready,
    gelato_fetchskd_ifetch_if.master ifetch_if,
    output logic              busy
);

    fetch_state_e state_q [NUM_WARPS];
    fetch_state_e state_d [NUM_WARPS];
    fetch_ctx_t   ctx_q   [NUM_WARPS];
    fetch_ctx_t   ctx_d   [NUM_WARPS];

    warp_num_t        ptr_q, ptr_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;
    addr_t            pc_q, pc_d;
    warp_num_t        wn_q, wn_d;
    split_table_num_t stn_q, stn_d;

    logic [NUM_WARPS-1:0] req;
    logic                 arb_valid;
    warp_num_t            arb_idx;
    logic                 grant;

    always_comb begin
        req = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            req[w] = (state_q[w] == READY);
        end
    end

    gelato_rr_arbiter #(
        .N (NUM_WARPS)
    ) u_arb (
        .req       (req),
        .ptr       (ptr_q),
        .gnt_valid (arb_valid),
        .gnt_idx   (arb_idx)
    );

    assign grant = ifetch_ready & arb_valid;

    // Finish is applied last so it overrides launch and update.
    always_comb begin
        state_d = state_q;
        ctx_d   = ctx_q;
        busy_d  = 1'b0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            if (grant && arb_idx == warp_num_t'(w)) begin
                state_d[w] = WAIT;
            end
            if (launch_valid
                && launch_warp_num == warp_num_t'(w)
                && state_q[w] == IDLE) begin
                state_d[w] = READY;
                ctx_d[w]   = '{pc: launch_pc,
                               split_table_num: launch_split_table_num};
            end
            if (update_valid
                && update_warp_num == warp_num_t'(w)
                && state_q[w] == WAIT) begin
                state_d[w] = READY;
                ctx_d[w]   = '{pc: update_pc,
                               split_table_num: update_split_table_num};
            end
            if (finish_valid && finish_warp_num == warp_num_t'(w)) begin
                state_d[w] = IDLE;
            end
            busy_d = busy_d | (state_d[w] != IDLE);
        end
    end

    always_comb begin
        ptr_d   = ptr_q;
        valid_d = grant;
        pc_d    = pc_q;
        wn_d    = wn_q;
        stn_d   = stn_q;
        if (grant) begin
            ptr_d = arb_idx + warp_num_t'(1);
            pc_d  = ctx_q[arb_idx].pc;
            wn_d  = arb_idx;
            stn_d = ctx_q[arb_idx].split_table_num;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                state_q[w] <= IDLE;
            end
            ptr_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            pc_q    <= '0;
            wn_q    <= '0;
            stn_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            pc_q    <= pc_d;
            wn_q    <= wn_d;
            stn_q   <= stn_d;
        end
    end

    // Context is only meaningful once a warp leaves IDLE.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ctx_q <= ctx_d;
        end
    end

    assign ifetch_if.valid           = valid_q;
    assign ifetch_if.pc              = pc_q;
    assign ifetch_if.warp_num        = wn_q;
    assign ifetch_if.split_table_num = stn_q;
    assign busy                      = busy_q;

endmodule
